// File: rtl/deconv_stream_accum_if.sv
// Stream bus for deconv_stream_accum.
// Input side: one (weight column, feature column) beat per handshake.
// Output side: finished output columns.
interface deconv_stream_accum_if #(
  parameter int BIT_WIDTH    = 8,
  parameter int WEIGHT_SIZE  = 5,
  parameter int FEATURE_SIZE = 8,
  parameter int STRIDE       = 2,
  parameter int ACC_WIDTH    = 24
);
  localparam int N_PIX_OUT = (FEATURE_SIZE - 1) * STRIDE + WEIGHT_SIZE;

  logic [BIT_WIDTH*WEIGHT_SIZE-1:0]  i_weight_col;
  logic [BIT_WIDTH*FEATURE_SIZE-1:0] i_feature_col;
  logic                              i_valid;
  logic                              i_last_col;
  logic                              o_ready;
  logic [ACC_WIDTH*N_PIX_OUT-1:0]    o_col;
  logic                              o_valid;
  logic                              o_last;
  logic                              i_ready;

  modport master (
    output i_weight_col, i_feature_col, i_valid, i_last_col, i_ready,
    input  o_ready, o_col, o_valid, o_last
  );

  modport slave (
    input  i_weight_col, i_feature_col, i_valid, i_last_col, i_ready,
    output o_ready, o_col, o_valid, o_last
  );
endinterface

// File: rtl/deconv_stream_accum.sv
// Streaming transposed-convolution column engine.
// Each accepted beat scatters feature*weight products into one slot of a
// K-slot ring of partial output columns. Once all K*C beats of an input
// column are in, S finished columns are emitted. After the last input
// column of a map, the remaining K-S slots are flushed.
module deconv_stream_accum #(
  parameter int BIT_WIDTH    = 8,
  parameter int WEIGHT_SIZE  = 5,
  parameter int FEATURE_SIZE = 8,
  parameter int STRIDE       = 2,
  parameter int N_CHANNEL    = 4,
  parameter int ACC_WIDTH    = 24
) (
  input logic                  i_clk,
  input logic                  i_rst,
  deconv_stream_accum_if.slave bus
);
  localparam int K         = WEIGHT_SIZE;
  localparam int F         = FEATURE_SIZE;
  localparam int S         = STRIDE;
  localparam int C         = N_CHANNEL;
  localparam int N_PIX_OUT = (F - 1) * S + K;
  localparam int KW        = (K > 1) ? $clog2(K) : 1;
  localparam int CW        = (C > 1) ? $clog2(C) : 1;
  localparam int PW        = 2 * BIT_WIDTH;
  // With K == S there is nothing left to flush; FLUSH_N is kept >= 1 so
  // the compare constant below stays non-negative.
  localparam bit NO_FLUSH  = (K == S);
  localparam int FLUSH_N   = (K > S) ? (K - S) : 1;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_EMIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                      state_r, state_nx_s;
  logic [KW-1:0]               base_r, base_nx_s;
  logic [KW-1:0]               kc_r, kc_nx_s;
  logic [KW-1:0]               cnt_r, cnt_nx_s;
  logic [CW-1:0]               ch_r, ch_nx_s;
  logic                        last_flag_r, last_flag_nx_s;
  logic signed [ACC_WIDTH-1:0] ring_r     [K][N_PIX_OUT];
  logic signed [ACC_WIDTH-1:0] ring_nx_s  [K][N_PIX_OUT];
  logic signed [ACC_WIDTH-1:0] beat_sum_s [N_PIX_OUT];
  logic signed [ACC_WIDTH-1:0] col_r      [N_PIX_OUT];
  logic                        valid_r, last_r, ready_r;
  logic                        last_nx_s;
  logic [KW:0]                 slot_sum_s;
  logic [KW-1:0]               slot_s;
  logic [KW-1:0]               base_inc_s;
  logic                        in_fire_s;
  logic                        out_fire_s;

  assign in_fire_s  = bus.i_valid & ready_r;
  assign out_fire_s = valid_r & bus.i_ready;

  // Ring slot addressed by this beat, and the ring head advanced by one.
  always_comb begin
    slot_sum_s = {1'b0, base_r} + {1'b0, kc_r};
    if (slot_sum_s >= (KW+1)'(K)) begin
      slot_s = KW'(slot_sum_s - (KW+1)'(K));
    end else begin
      slot_s = slot_sum_s[KW-1:0];
    end
    if (base_r == KW'(K - 1)) begin
      base_inc_s = KW'(0);
    end else begin
      base_inc_s = base_r + KW'(1);
    end
  end

  // Product column of one beat; every contribution to a pixel is summed here.
  always_comb begin
    logic signed [PW-1:0] prod_v;
    prod_v = '0;
    for (int p = 0; p < N_PIX_OUT; p++) begin
      beat_sum_s[p] = '0;
    end
    for (int f = 0; f < F; f++) begin
      for (int r = 0; r < K; r++) begin
        prod_v = $signed(bus.i_feature_col[f*BIT_WIDTH +: BIT_WIDTH]) *
                 $signed(bus.i_weight_col[r*BIT_WIDTH +: BIT_WIDTH]);
        beat_sum_s[f*S + r] = beat_sum_s[f*S + r] + ACC_WIDTH'(prod_v);
      end
    end
  end

  // Next-state logic: beat accumulation, emission, flush and ring bookkeeping.
  always_comb begin
    state_nx_s     = state_r;
    base_nx_s      = base_r;
    kc_nx_s        = kc_r;
    ch_nx_s        = ch_r;
    cnt_nx_s       = cnt_r;
    last_flag_nx_s = last_flag_r;
    ring_nx_s      = ring_r;
    case (state_r)
      ST_ACCUM: begin
        if (in_fire_s) begin
          for (int p = 0; p < N_PIX_OUT; p++) begin
            ring_nx_s[slot_s][p] = ring_r[slot_s][p] + beat_sum_s[p];
          end
          if (ch_r == CW'(C - 1)) begin
            ch_nx_s = CW'(0);
            if (kc_r == KW'(K - 1)) begin
              kc_nx_s        = KW'(0);
              cnt_nx_s       = KW'(0);
              last_flag_nx_s = bus.i_last_col;
              state_nx_s     = ST_EMIT;
            end else begin
              kc_nx_s = kc_r + KW'(1);
            end
          end else begin
            ch_nx_s = ch_r + CW'(1);
          end
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_EMIT: begin
        if (out_fire_s) begin
          for (int p = 0; p < N_PIX_OUT; p++) begin
            ring_nx_s[base_r][p] = '0;
          end
          base_nx_s = base_inc_s;
          if (cnt_r == KW'(S - 1)) begin
            cnt_nx_s = KW'(0);
            if (last_flag_r && NO_FLUSH) begin
              base_nx_s      = KW'(0);
              last_flag_nx_s = 1'b0;
              state_nx_s     = ST_ACCUM;
            end else if (last_flag_r) begin
              state_nx_s = ST_FLUSH;
            end else begin
              state_nx_s = ST_ACCUM;
            end
          end else begin
            cnt_nx_s = cnt_r + KW'(1);
          end
        end else begin
          state_nx_s = ST_EMIT;
        end
      end
      ST_FLUSH: begin
        if (out_fire_s) begin
          for (int p = 0; p < N_PIX_OUT; p++) begin
            ring_nx_s[base_r][p] = '0;
          end
          if (cnt_r == KW'(FLUSH_N - 1)) begin
            base_nx_s      = KW'(0);
            cnt_nx_s       = KW'(0);
            last_flag_nx_s = 1'b0;
            state_nx_s     = ST_ACCUM;
          end else begin
            base_nx_s = base_inc_s;
            cnt_nx_s  = cnt_r + KW'(1);
          end
        end else begin
          state_nx_s = ST_FLUSH;
        end
      end
      default: begin
        state_nx_s = ST_ACCUM;
      end
    endcase
  end

  // Final-column marker: the last flushed slot, or the S-th emit when nothing is flushed.
  always_comb begin
    if ((state_nx_s == ST_FLUSH) && (cnt_nx_s == KW'(FLUSH_N - 1))) begin
      last_nx_s = 1'b1;
    end else if (NO_FLUSH && (state_nx_s == ST_EMIT) && last_flag_nx_s &&
                 (cnt_nx_s == KW'(S - 1))) begin
      last_nx_s = 1'b1;
    end else begin
      last_nx_s = 1'b0;
    end
  end

  // State, ring and registered outputs; outputs mirror the next head slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_ACCUM;
      base_r      <= KW'(0);
      kc_r        <= KW'(0);
      cnt_r       <= KW'(0);
      ch_r        <= CW'(0);
      last_flag_r <= 1'b0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      ready_r     <= 1'b0;
      for (int k = 0; k < K; k++) begin
        for (int p = 0; p < N_PIX_OUT; p++) begin
          ring_r[k][p] <= '0;
        end
      end
      for (int p = 0; p < N_PIX_OUT; p++) begin
        col_r[p] <= '0;
      end
    end else begin
      state_r     <= state_nx_s;
      base_r      <= base_nx_s;
      kc_r        <= kc_nx_s;
      cnt_r       <= cnt_nx_s;
      ch_r        <= ch_nx_s;
      last_flag_r <= last_flag_nx_s;
      valid_r     <= (state_nx_s != ST_ACCUM);
      last_r      <= last_nx_s;
      ready_r     <= (state_nx_s == ST_ACCUM);
      for (int k = 0; k < K; k++) begin
        for (int p = 0; p < N_PIX_OUT; p++) begin
          ring_r[k][p] <= ring_nx_s[k][p];
        end
      end
      for (int p = 0; p < N_PIX_OUT; p++) begin
        col_r[p] <= ring_nx_s[base_nx_s][p];
      end
    end
  end

  for (genvar gp = 0; gp < N_PIX_OUT; gp++) begin : g_pack
    assign bus.o_col[gp*ACC_WIDTH +: ACC_WIDTH] = col_r[gp];
  end

  assign bus.o_valid = valid_r;
  assign bus.o_last  = last_r;
  assign bus.o_ready = ready_r;
endmodule

// File: tb/tb_deconv_stream_accum.sv
// Directed bench for deconv_stream_accum.
// DUT A: K=3 S=2 F=2 C=2, ACC=24.
// DUTs B/C: K=S=2 F=2 C=4 with ACC=16 and ACC=24 respectively (signed wrap).
module tb_deconv_stream_accum;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [119:0] exp_a [5];

  always #5 clk = ~clk;

  deconv_stream_accum_if #(.BIT_WIDTH(8), .WEIGHT_SIZE(3), .FEATURE_SIZE(2), .STRIDE(2), .ACC_WIDTH(24)) bus_a ();
  deconv_stream_accum_if #(.BIT_WIDTH(8), .WEIGHT_SIZE(2), .FEATURE_SIZE(2), .STRIDE(2), .ACC_WIDTH(16)) bus_b ();
  deconv_stream_accum_if #(.BIT_WIDTH(8), .WEIGHT_SIZE(2), .FEATURE_SIZE(2), .STRIDE(2), .ACC_WIDTH(24)) bus_c ();

  deconv_stream_accum #(.BIT_WIDTH(8), .WEIGHT_SIZE(3), .FEATURE_SIZE(2), .STRIDE(2),
                        .N_CHANNEL(2), .ACC_WIDTH(24)) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  deconv_stream_accum #(.BIT_WIDTH(8), .WEIGHT_SIZE(2), .FEATURE_SIZE(2), .STRIDE(2),
                        .N_CHANNEL(4), .ACC_WIDTH(16)) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));
  deconv_stream_accum #(.BIT_WIDTH(8), .WEIGHT_SIZE(2), .FEATURE_SIZE(2), .STRIDE(2),
                        .N_CHANNEL(4), .ACC_WIDTH(24)) u_dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [119:0] col_a(input int p0, input int p1, input int p2, input int p3, input int p4);
    return {24'(p4), 24'(p3), 24'(p2), 24'(p1), 24'(p0)};
  endfunction

  // One beat into DUT A; waits (bounded) for o_ready, then lets one edge accept it.
  task automatic send_beat_a(input logic [23:0] w, input logic [15:0] f, input logic last);
    int n = 0;
    bus_a.i_weight_col  = w;
    bus_a.i_feature_col = f;
    bus_a.i_last_col    = last;
    bus_a.i_valid       = 1'b1;
    while (bus_a.o_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) check_val("a_beat_timeout", {127'd0, bus_a.o_ready}, 128'd1);
    @(posedge clk); #1;
    bus_a.i_valid    = 1'b0;
    bus_a.i_last_col = 1'b0;
  endtask

  // Full column to DUT A: weights all 1, feature [1,2]; optional idle gap mid-column.
  task automatic send_col_a(input logic last, input bit gap);
    for (int b = 0; b < 6; b++) begin
      if (gap && b == 3) begin
        repeat (3) begin @(posedge clk); #1; end
      end
      send_beat_a(24'h010101, 16'h0201, last);
    end
  endtask

  // Collect n columns from DUT A, expected exp_a[first..], o_last at index last_idx.
  task automatic collect_a(input int first, input int n, input int last_idx, input bit stall);
    int got = 0;
    int cyc = 0;
    bit held_chk = 1'b0;
    logic [119:0] held = '0;
    logic [3:0] pat = 4'b1001;
    while (got < n && cyc < 100) begin
      bus_a.i_ready = stall ? pat[cyc % 4] : 1'b1;
      if (held_chk) begin
        check_val("a_hold_col", {8'd0, bus_a.o_col}, {8'd0, held});
        check_val("a_hold_valid", {127'd0, bus_a.o_valid}, 128'd1);
      end
      held_chk = 1'b0;
      if (bus_a.o_valid === 1'b1) begin
        check_val("a_ready_low", {127'd0, bus_a.o_ready}, 128'd0);
        if (bus_a.i_ready) begin
          check_val("a_col", {8'd0, bus_a.o_col}, {8'd0, exp_a[first + got]});
          check_val("a_last", {127'd0, bus_a.o_last}, (first + got == last_idx) ? 128'd1 : 128'd0);
          got++;
        end else begin
          held     = bus_a.o_col;
          held_chk = 1'b1;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    bus_a.i_ready = 1'b0;
    check_val("a_col_count", 128'(got), 128'(n));
    check_val("a_ready_back", {127'd0, bus_a.o_ready}, 128'd1);
    check_val("a_valid_idle", {127'd0, bus_a.o_valid}, 128'd0);
  endtask

  // K=S=2 wrap run on B and C in lockstep: weights and features all -128.
  task automatic run_bc();
    int n;
    int got = 0;
    int cyc = 0;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      bus_b.i_weight_col = 16'h8080; bus_b.i_feature_col = 16'h8080;
      bus_c.i_weight_col = 16'h8080; bus_c.i_feature_col = 16'h8080;
      bus_b.i_last_col = 1'b1; bus_c.i_last_col = 1'b1;
      bus_b.i_valid = 1'b1; bus_c.i_valid = 1'b1;
      while (bus_c.o_ready !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 20) check_val("bc_beat_timeout", {127'd0, bus_c.o_ready}, 128'd1);
      @(posedge clk); #1;
    end
    bus_b.i_valid = 1'b0; bus_c.i_valid = 1'b0;
    check_val("bc_valid_latency", {126'd0, bus_b.o_valid, bus_c.o_valid}, 128'd3);
    while (got < 2 && cyc < 50) begin
      bus_b.i_ready = 1'b1; bus_c.i_ready = 1'b1;
      if (bus_c.o_valid === 1'b1) begin
        check_val("b_col_wrap16", {64'd0, bus_b.o_col}, 128'd0);
        check_val("c_col_acc24", {32'd0, bus_c.o_col}, {32'd0, 96'h010000_010000_010000_010000});
        check_val("c_last", {127'd0, bus_c.o_last}, (got == 1) ? 128'd1 : 128'd0);
        check_val("b_last", {127'd0, bus_b.o_last}, (got == 1) ? 128'd1 : 128'd0);
        got++;
      end
      @(posedge clk); #1; cyc++;
    end
    bus_b.i_ready = 1'b0; bus_c.i_ready = 1'b0;
    check_val("bc_col_count", 128'(got), 128'd2);
    check_val("c_ready_back", {127'd0, bus_c.o_ready}, 128'd1);
    check_val("c_valid_idle", {127'd0, bus_c.o_valid}, 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.i_weight_col = '0; bus_a.i_feature_col = '0; bus_a.i_valid = 1'b0;
    bus_a.i_last_col = 1'b0; bus_a.i_ready = 1'b0;
    bus_b.i_weight_col = '0; bus_b.i_feature_col = '0; bus_b.i_valid = 1'b0;
    bus_b.i_last_col = 1'b0; bus_b.i_ready = 1'b0;
    bus_c.i_weight_col = '0; bus_c.i_feature_col = '0; bus_c.i_valid = 1'b0;
    bus_c.i_last_col = 1'b0; bus_c.i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check_val("rst_valid", {127'd0, bus_a.o_valid}, 128'd0);
    check_val("rst_last", {127'd0, bus_a.o_last}, 128'd0);
    check_val("rst_col", {8'd0, bus_a.o_col}, 128'd0);
    check_val("rst_ready", {127'd0, bus_a.o_ready}, 128'd0);
    rst = 1'b0;
    #1;
    check_val("ready_before_edge", {127'd0, bus_a.o_ready}, 128'd0);
    @(posedge clk); #1;
    check_val("ready_after_edge", {127'd0, bus_a.o_ready}, 128'd1);

    // Single column, last
    for (int i = 0; i < 3; i++) exp_a[i] = col_a(2, 2, 6, 4, 4);
    send_col_a(1'b1, 1'b0);
    check_val("a_valid_latency", {127'd0, bus_a.o_valid}, 128'd1);
    collect_a(0, 3, 2, 1'b0);

    // Two columns with overlap-add; idle gap inside the first column
    exp_a[0] = col_a(2, 2, 6, 4, 4);
    exp_a[1] = col_a(2, 2, 6, 4, 4);
    exp_a[2] = col_a(4, 4, 12, 8, 8);
    exp_a[3] = col_a(2, 2, 6, 4, 4);
    exp_a[4] = col_a(2, 2, 6, 4, 4);
    send_col_a(1'b0, 1'b1);
    check_val("a_valid_latency2", {127'd0, bus_a.o_valid}, 128'd1);
    collect_a(0, 2, 4, 1'b0);
    send_col_a(1'b1, 1'b0);
    collect_a(2, 3, 4, 1'b0);

    // Backpressure 1,0,0,1 pattern
    for (int i = 0; i < 3; i++) exp_a[i] = col_a(2, 2, 6, 4, 4);
    send_col_a(1'b1, 1'b0);
    collect_a(0, 3, 2, 1'b1);

    // Signed wrap and K == S (no flush)
    run_bc();

    // Reset mid-column
    for (int b = 0; b < 3; b++) send_beat_a(24'h010101, 16'h0201, 1'b0);
    rst = 1'b1;
    #2;
    check_val("midrst_ready", {127'd0, bus_a.o_ready}, 128'd0);
    check_val("midrst_valid", {127'd0, bus_a.o_valid}, 128'd0);
    @(posedge clk); #1;
    check_val("midrst_ready_hold", {127'd0, bus_a.o_ready}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("midrst_ready_back", {127'd0, bus_a.o_ready}, 128'd1);

    // Reset mid-emission: o_valid must drop without a clock edge
    send_col_a(1'b1, 1'b0);
    check_val("emit_valid_pre_rst", {127'd0, bus_a.o_valid}, 128'd1);
    rst = 1'b1;
    #1;
    check_val("emit_rst_valid_async", {127'd0, bus_a.o_valid}, 128'd0);
    check_val("emit_rst_col", {8'd0, bus_a.o_col}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean rerun after reset reproduces the single-column result
    for (int i = 0; i < 3; i++) exp_a[i] = col_a(2, 2, 6, 4, 4);
    send_col_a(1'b1, 1'b0);
    collect_a(0, 3, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
